// File: rtl/led_pkg.sv
// Shared types and helpers for the breathing LED driver.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        HOLD = 2'd2,
        DOWN = 2'd3
    } state_t;

    // Full-scale level for a PWM counter of the given width.
    function automatic int unsigned pwm_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/led_breathe_pwm_channel.sv
// One PWM output pin: registered compare of the shared frame counter against a duty.
module pwm_channel #(
    parameter int PWM_BITS   = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pin
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pin <= ACTIVE_LOW;
        end else begin
            pin <= (pwm_cnt < duty) ^ ACTIVE_LOW;
        end
    end

endmodule

// File: rtl/led_breathe.sv
// Breathing LED driver: prescaled ramp FSM feeding three PWM channels through a
// frame-aligned shadow level so duty never changes mid-frame.
module led_breathe
    import led_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int STEP_DIV   = 46875,
    parameter int HOLD_STEPS = 128,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    output logic [2:0]          led_o,
    output logic [PWM_BITS-1:0] level_o,
    output logic                cycle_done_o
);

    localparam int unsigned MAX_I = pwm_max(PWM_BITS);
    localparam logic [PWM_BITS-1:0] MAX = MAX_I[PWM_BITS-1:0];
    localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

    localparam int PRE_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

    state_t              state, state_nx;
    logic [PWM_BITS-1:0] level, level_nx;
    logic [PWM_BITS-1:0] lvl_s;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PRE_W-1:0]    presc;
    logic [HOLD_W-1:0]   hold_cnt, hold_nx;
    logic                done_nx;
    logic                step_tick;
    logic [PWM_BITS-1:0] duty0, duty1, duty2;

    function automatic logic [PWM_BITS-1:0] sat_inc(input logic [PWM_BITS-1:0] v);
        return (v == MAX) ? MAX : v + ONE;
    endfunction

    function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] v);
        return (v == '0) ? '0 : v - ONE;
    endfunction

    assign step_tick = (state != IDLE) && (presc == PRE_LAST);

    always_comb begin
        state_nx = state;
        level_nx = level;
        hold_nx  = hold_cnt;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                level_nx = '0;
                if (en) state_nx = UP;
            end
            UP: begin
                if (!en) begin
                    state_nx = DOWN;
                end else if (step_tick) begin
                    level_nx = sat_inc(level);
                    if (level == MAX - ONE) begin
                        state_nx = (HOLD_STEPS == 0) ? DOWN : HOLD;
                        hold_nx  = '0;
                    end
                end
            end
            HOLD: begin
                if (!en) begin
                    state_nx = DOWN;
                end else if (step_tick) begin
                    if (hold_cnt == HOLD_LAST) state_nx = DOWN;
                    else                       hold_nx  = hold_cnt + 1'b1;
                end
            end
            DOWN: begin
                // en is ignored here until the fade-out reaches zero
                if (step_tick) begin
                    level_nx = sat_dec(level);
                    if (level <= ONE) begin
                        done_nx  = 1'b1;
                        state_nx = en ? UP : IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            level        <= '0;
            hold_cnt     <= '0;
            presc        <= '0;
            pwm_cnt      <= '0;
            lvl_s        <= '0;
            cycle_done_o <= 1'b0;
        end else begin
            state        <= state_nx;
            level        <= level_nx;
            hold_cnt     <= hold_nx;
            cycle_done_o <= done_nx;
            if (state == IDLE)          presc <= '0;
            else if (presc == PRE_LAST) presc <= '0;
            else                        presc <= presc + 1'b1;
            pwm_cnt <= pwm_cnt + ONE;
            // shadow captures the pre-update level, so a coincident step lands next frame
            if (pwm_cnt == MAX) lvl_s <= level;
        end
    end

    assign duty0   = lvl_s;
    assign duty1   = MAX - lvl_s;
    assign duty2   = lvl_s >> 1;
    assign level_o = level;

    pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_ch0 (
        .clk(clk), .rst_n(rst_n), .pwm_cnt(pwm_cnt), .duty(duty0), .pin(led_o[0])
    );
    pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_ch1 (
        .clk(clk), .rst_n(rst_n), .pwm_cnt(pwm_cnt), .duty(duty1), .pin(led_o[1])
    );
    pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_ch2 (
        .clk(clk), .rst_n(rst_n), .pwm_cnt(pwm_cnt), .duty(duty2), .pin(led_o[2])
    );

endmodule

// File: tb/tb_led_breathe.sv
// Bench for led_breathe: vector table, hand-built duty/reset sequences and random en
// against a behavioural model; an ACTIVE_LOW twin must mirror the normal instance.
module tb_led_breathe;

    localparam int PWM_BITS   = 4;
    localparam int STEP_DIV   = 2;
    localparam int HOLD_STEPS = 1;
    localparam int MAXV       = (1 << PWM_BITS) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en = 1'b0;
    logic [2:0]          led_o, led_al;
    logic [PWM_BITS-1:0] level_o, level_al;
    logic                done_o, done_al;

    led_breathe #(.PWM_BITS(PWM_BITS), .STEP_DIV(STEP_DIV), .HOLD_STEPS(HOLD_STEPS),
                  .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .led_o(led_o), .level_o(level_o), .cycle_done_o(done_o)
    );

    led_breathe #(.PWM_BITS(PWM_BITS), .STEP_DIV(STEP_DIV), .HOLD_STEPS(HOLD_STEPS),
                  .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .en(en),
        .led_o(led_al), .level_o(level_al), .cycle_done_o(done_al)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: ramp direction as +1/0/-1, brightness as a plain integer.
    bit         m_run;
    int         m_dir, m_lvl, m_hold, m_pre, m_pwm, m_sh, m_done;
    logic [2:0] m_led;

    int cnt[3];
    int cnt_al[3];

    typedef struct {
        bit en;
        int cycles;
        int exp_lvl;
        bit exp_done;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit tick;
        int pwm_old = m_pwm;
        int sh_old  = m_sh;
        if (!rst_n) begin
            m_run = 0; m_dir = 0; m_lvl = 0; m_hold = 0; m_pre = 0;
            m_pwm = 0; m_sh = 0; m_done = 0; m_led = 3'b000;
            return;
        end
        tick = m_run && (m_pre == STEP_DIV - 1);
        m_led[0] = pwm_old < sh_old;
        m_led[1] = pwm_old < (MAXV - sh_old);
        m_led[2] = pwm_old < (sh_old / 2);
        if (pwm_old == MAXV) m_sh = m_lvl;
        m_pwm  = (pwm_old + 1) % (MAXV + 1);
        m_done = 0;
        if (!m_run) begin
            m_pre = 0;
            if (en) begin m_run = 1; m_dir = 1; end
        end else begin
            m_pre = (m_pre + 1) % STEP_DIV;
            if (m_dir >= 0 && !en) begin
                m_dir = -1;
            end else if (tick) begin
                if (m_dir > 0) begin
                    m_lvl++;
                    if (m_lvl == MAXV) begin
                        m_dir  = (HOLD_STEPS == 0) ? -1 : 0;
                        m_hold = 0;
                    end
                end else if (m_dir == 0) begin
                    if (m_hold == HOLD_STEPS - 1) m_dir = -1;
                    else m_hold++;
                end else begin
                    if (m_lvl > 0) m_lvl--;
                    if (m_lvl == 0) begin
                        m_done = 1;
                        if (en) m_dir = 1;
                        else    m_run = 0;
                    end
                end
            end
        end
    endtask

    task automatic step();
        logic [2:0] inv;
        model_step();
        @(posedge clk);
        @(negedge clk);
        inv = ~m_led;
        chk("level", level_o, m_lvl);
        chk("done", done_o, m_done);
        chk("led", led_o, m_led);
        chk("led_al", led_al, inv);
        chk("level_al", level_al, m_lvl);
        chk("done_al", done_al, m_done);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic frame();
        for (int i = 0; i < 3; i++) begin cnt[i] = 0; cnt_al[i] = 0; end
        repeat (16) begin
            step();
            for (int i = 0; i < 3; i++) begin
                cnt[i]    += int'(led_o[i] === 1'b1);
                cnt_al[i] += int'(led_al[i] === 1'b0);
            end
        end
    endtask

    task automatic check_frame(input int e0, input int e1, input int e2);
        chk("duty_c0", cnt[0], e0);
        chk("duty_c1", cnt[1], e1);
        chk("duty_c2", cnt[2], e2);
        chk("duty_al_c0", cnt_al[0], e0);
        chk("duty_al_c1", cnt_al[1], e1);
        chk("duty_al_c2", cnt_al[2], e2);
    endtask

    initial begin
        // rows: en, clocks to advance, expected level_o and cycle_done_o afterwards
        tbl.push_back('{1, 1, 0, 0});   tbl.push_back('{1, 1, 0, 0});
        tbl.push_back('{1, 1, 1, 0});   tbl.push_back('{1, 2, 2, 0});
        tbl.push_back('{1, 26, 15, 0}); tbl.push_back('{1, 2, 15, 0});
        tbl.push_back('{1, 2, 14, 0});  tbl.push_back('{1, 26, 1, 0});
        tbl.push_back('{1, 1, 1, 0});   tbl.push_back('{1, 1, 0, 1});
        tbl.push_back('{1, 1, 0, 0});   tbl.push_back('{1, 1, 1, 0});
        tbl.push_back('{1, 10, 6, 0});  tbl.push_back('{0, 1, 6, 0});
        tbl.push_back('{0, 1, 5, 0});   tbl.push_back('{0, 8, 1, 0});
        tbl.push_back('{0, 1, 1, 0});   tbl.push_back('{0, 1, 0, 1});
        tbl.push_back('{0, 1, 0, 0});   tbl.push_back('{0, 10, 0, 0});
        tbl.push_back('{1, 1, 0, 0});   tbl.push_back('{1, 1, 0, 0});
        tbl.push_back('{1, 1, 1, 0});

        // reset held with en high
        en = 1'b1;
        rst_n = 1'b0;
        repeat (5) begin
            step();
            chk("rst_led", led_o, 3'b000);
            chk("rst_led_al", led_al, 3'b111);
            chk("rst_level", level_o, 0);
            chk("rst_done", done_o, 0);
        end
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            en = tbl[i].en;
            repeat (tbl[i].cycles) step();
            chk($sformatf("tbl%0d_level", i), level_o, tbl[i].exp_lvl);
            chk($sformatf("tbl%0d_done", i), done_o, tbl[i].exp_done);
        end

        // duty: shadow 15 for frame 2, shadow 8 for frame 3
        reset_dut();
        en = 1'b1;
        repeat (32) step();
        frame();
        check_frame(15, 0, 7);
        frame();
        check_frame(8, 7, 4);

        // step tick coincident with frame wrap: shadow keeps old level 6
        reset_dut();
        en = 1'b0;
        step();
        en = 1'b1;
        repeat (15) step();
        chk("wrap_level", level_o, 7);
        frame();
        check_frame(6, 9, 3);
        frame();
        check_frame(14, 1, 7);

        // reset asserted while holding at MAX
        reset_dut();
        en = 1'b1;
        repeat (31) step();
        chk("hold_level", level_o, 15);
        rst_n = 1'b0;
        step();
        chk("hold_rst_level", level_o, 0);
        chk("hold_rst_led", led_o, 3'b000);
        chk("hold_rst_led_al", led_al, 3'b111);
        chk("hold_rst_done", done_o, 0);
        rst_n = 1'b1;

        // random en with occasional reset
        repeat (3000) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            rst_n = ($urandom_range(0, 999) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
